// File: rtl/mms_pkg.sv
// Shared MMU types: ITLB refill FSM states, widths and the
// refill payload bundle written into an ITLB entry.
package mms_pkg;

   localparam int TLB_ENTRY_SIZE = 32;
   localparam int MMS_VPN_W      = 27;
   localparam int MMS_PPN_W      = 44;
   localparam int MMS_PERM_W     = 8;
   localparam int MMS_LVL_W      = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_SEL,
      ST_WRITE,
      ST_FAULT
   } itlb_refill_state_e;

   typedef struct packed {
      logic [MMS_VPN_W-1:0]  vpn;
      logic [MMS_PPN_W-1:0]  ppn;
      logic [MMS_PERM_W-1:0] perm;
      logic [MMS_LVL_W-1:0]  level;
   } itlb_refill_entry_t;

endpackage

// File: rtl/itlb_refill_ctrl.sv
// ITLB miss sequencer: PTW request, victim select, entry write.
// Owns the per-entry valid vector shared with the PLRU and lookup.
module itlb_refill_ctrl
   import mms_pkg::*;
#(
   parameter int ENTRY_NUM = TLB_ENTRY_SIZE,
   parameter int VPN_W     = MMS_VPN_W,
   parameter int PPN_W     = MMS_PPN_W,
   parameter int PERM_W    = MMS_PERM_W
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 miss_vld_i,
   input  logic [VPN_W-1:0]     miss_vpn_i,
   output logic                 miss_rdy_o,
   output logic                 ptw_req_vld_o,
   input  logic                 ptw_req_rdy_i,
   output logic [VPN_W-1:0]     ptw_req_vpn_o,
   input  logic                 ptw_resp_vld_i,
   input  logic [PPN_W-1:0]     ptw_resp_ppn_i,
   input  logic [PERM_W-1:0]    ptw_resp_perm_i,
   input  logic [1:0]           ptw_resp_level_i,
   input  logic                 ptw_resp_fault_i,
   input  logic                 flush_i,
   output logic [ENTRY_NUM-1:0] entry_valid_o,
   output logic                 victim_init_en_o,
   input  logic [ENTRY_NUM-1:0] victim_onehot_i,
   output logic                 refill_vld_o,
   output logic [ENTRY_NUM-1:0] refill_onehot_o,
   output logic [VPN_W-1:0]     refill_vpn_o,
   output logic [PPN_W-1:0]     refill_ppn_o,
   output logic [PERM_W-1:0]    refill_perm_o,
   output logic [1:0]           refill_level_o,
   output logic                 fault_vld_o,
   output logic [VPN_W-1:0]     fault_vpn_o
);

   itlb_refill_state_e   state_q, state_d;
   itlb_refill_entry_t   ent_q, ent_d;
   logic                 kill_q, kill_d;
   logic [ENTRY_NUM-1:0] valid_q, valid_d;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= ST_IDLE;
         ent_q   <= '0;
         kill_q  <= 1'b0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         ent_q   <= ent_d;
         kill_q  <= kill_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ent_d   = ent_q;
      kill_d  = kill_q;
      valid_d = valid_q;
      unique case (state_q)
         ST_IDLE: begin
            if (miss_vld_i) begin
               ent_d.vpn = miss_vpn_i;
               state_d   = ST_REQ;
            end
         end
         ST_REQ: begin
            if (flush_i) kill_d = 1'b1;
            if (ptw_req_rdy_i) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (flush_i) kill_d = 1'b1;
            if (ptw_resp_vld_i) begin
               // A walk started before sfence is stale: drain and drop it.
               if (kill_q || flush_i) begin
                  kill_d  = 1'b0;
                  state_d = ST_IDLE;
               end else if (ptw_resp_fault_i) begin
                  state_d = ST_FAULT;
               end else begin
                  ent_d.ppn   = ptw_resp_ppn_i;
                  ent_d.perm  = ptw_resp_perm_i;
                  ent_d.level = ptw_resp_level_i;
                  state_d     = ST_SEL;
               end
            end
         end
         ST_SEL: begin
            state_d = flush_i ? ST_IDLE : ST_WRITE;
         end
         ST_WRITE: begin
            valid_d = valid_q | victim_onehot_i;
            state_d = ST_IDLE;
         end
         ST_FAULT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (flush_i) valid_d = '0;
   end

   assign miss_rdy_o       = (state_q == ST_IDLE);
   assign ptw_req_vld_o    = (state_q == ST_REQ);
   assign ptw_req_vpn_o    = ent_q.vpn;
   assign victim_init_en_o = (state_q == ST_SEL);
   assign entry_valid_o    = valid_q;
   assign refill_vld_o     = (state_q == ST_WRITE) && !flush_i;
   assign refill_onehot_o  = (state_q == ST_WRITE) ? victim_onehot_i : '0;
   assign refill_vpn_o     = ent_q.vpn;
   assign refill_ppn_o     = ent_q.ppn;
   assign refill_perm_o    = ent_q.perm;
   assign refill_level_o   = ent_q.level;
   assign fault_vld_o      = (state_q == ST_FAULT);
   assign fault_vpn_o      = ent_q.vpn;

endmodule

// File: tb/tb_itlb_refill_ctrl.sv
// Directed bench for itlb_refill_ctrl with a scripted timeline model
// and a first-free PLRU stand-in.
module tb_itlb_refill_ctrl;

   logic        clk = 1'b0;
   logic        rstn_i = 1'b0;
   logic        miss_vld_i = 1'b0;
   logic [26:0] miss_vpn_i = '0;
   logic        miss_rdy_o;
   logic        ptw_req_vld_o;
   logic        ptw_req_rdy_i = 1'b0;
   logic [26:0] ptw_req_vpn_o;
   logic        ptw_resp_vld_i = 1'b0;
   logic [43:0] ptw_resp_ppn_i = '0;
   logic [7:0]  ptw_resp_perm_i = '0;
   logic [1:0]  ptw_resp_level_i = '0;
   logic        ptw_resp_fault_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [31:0] entry_valid_o;
   logic        victim_init_en_o;
   logic [31:0] victim_onehot_i = '0;
   logic        refill_vld_o;
   logic [31:0] refill_onehot_o;
   logic [26:0] refill_vpn_o;
   logic [43:0] refill_ppn_o;
   logic [7:0]  refill_perm_o;
   logic [1:0]  refill_level_o;
   logic        fault_vld_o;
   logic [26:0] fault_vpn_o;

   itlb_refill_ctrl dut (
      .clk_i            (clk),
      .rstn_i           (rstn_i),
      .miss_vld_i       (miss_vld_i),
      .miss_vpn_i       (miss_vpn_i),
      .miss_rdy_o       (miss_rdy_o),
      .ptw_req_vld_o    (ptw_req_vld_o),
      .ptw_req_rdy_i    (ptw_req_rdy_i),
      .ptw_req_vpn_o    (ptw_req_vpn_o),
      .ptw_resp_vld_i   (ptw_resp_vld_i),
      .ptw_resp_ppn_i   (ptw_resp_ppn_i),
      .ptw_resp_perm_i  (ptw_resp_perm_i),
      .ptw_resp_level_i (ptw_resp_level_i),
      .ptw_resp_fault_i (ptw_resp_fault_i),
      .flush_i          (flush_i),
      .entry_valid_o    (entry_valid_o),
      .victim_init_en_o (victim_init_en_o),
      .victim_onehot_i  (victim_onehot_i),
      .refill_vld_o     (refill_vld_o),
      .refill_onehot_o  (refill_onehot_o),
      .refill_vpn_o     (refill_vpn_o),
      .refill_ppn_o     (refill_ppn_o),
      .refill_perm_o    (refill_perm_o),
      .refill_level_o   (refill_level_o),
      .fault_vld_o      (fault_vld_o),
      .fault_vpn_o      (fault_vpn_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc_n = 0;
   int t_acc = 0;
   int refill_cyc = 0;
   int refill_cnt = 0;
   int fault_cnt = 0;
   logic [31:0] last_oh = '0;
   logic [26:0] last_fvpn = '0;

   bit          chk_en = 1'b0;
   logic [31:0] mdl_valid = '0;
   bit          exp_rdy, exp_req, exp_init, exp_refill, exp_fault, exp_rst;
   logic [31:0] exp_valid, exp_onehot;
   logic [26:0] exp_req_vpn, exp_fault_vpn, exp_vpn;
   logic [43:0] exp_ppn;
   logic [7:0]  exp_perm;
   logic [1:0]  exp_lvl;

   function automatic logic [31:0] pick(input logic [31:0] v);
      for (int i = 0; i < 32; i++)
         if (!v[i]) return 32'h1 << i;
      return 32'h0000_0080;
   endfunction

   // PLRU stand-in: first free entry, else a fixed replacement way.
   always @(posedge clk)
      if (victim_init_en_o) victim_onehot_i <= pick(entry_valid_o);

   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc_n);
      end
   endtask

   always @(negedge clk) begin
      if (refill_vld_o) begin
         refill_cnt++;
         refill_cyc = cyc_n;
         last_oh = refill_onehot_o;
      end
      if (fault_vld_o) begin
         fault_cnt++;
         last_fvpn = fault_vpn_o;
      end
      if (chk_en) begin
         chk("miss_rdy", {63'd0, miss_rdy_o}, {63'd0, exp_rdy});
         chk("req_vld", {63'd0, ptw_req_vld_o}, {63'd0, exp_req});
         chk("init_en", {63'd0, victim_init_en_o}, {63'd0, exp_init});
         chk("refill_vld", {63'd0, refill_vld_o}, {63'd0, exp_refill});
         chk("fault_vld", {63'd0, fault_vld_o}, {63'd0, exp_fault});
         chk("entry_valid", {32'd0, entry_valid_o}, {32'd0, exp_valid});
         chk("refill_oh", {32'd0, refill_onehot_o}, {32'd0, exp_onehot});
         if (exp_req)
            chk("req_vpn", {37'd0, ptw_req_vpn_o}, {37'd0, exp_req_vpn});
         if (exp_fault)
            chk("fault_vpn", {37'd0, fault_vpn_o}, {37'd0, exp_fault_vpn});
         if (exp_refill) begin
            chk("refill_vpn", {37'd0, refill_vpn_o}, {37'd0, exp_vpn});
            chk("refill_ppn", {20'd0, refill_ppn_o}, {20'd0, exp_ppn});
            chk("refill_perm", {56'd0, refill_perm_o}, {56'd0, exp_perm});
            chk("refill_lvl", {62'd0, refill_level_o}, {62'd0, exp_lvl});
         end
         if (exp_rst) begin
            chk("rst_req_vpn", {37'd0, ptw_req_vpn_o}, 64'd0);
            chk("rst_fault_vpn", {37'd0, fault_vpn_o}, 64'd0);
            chk("rst_payload", {refill_vpn_o, refill_ppn_o[36:0]}, 64'd0);
            chk("rst_perm_lvl", {54'd0, refill_perm_o, refill_level_o},
                64'd0);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_exp(input bit rdy);
      exp_rdy    = rdy;
      exp_req    = 1'b0;
      exp_init   = 1'b0;
      exp_refill = 1'b0;
      exp_fault  = 1'b0;
      exp_rst    = 1'b0;
      exp_onehot = '0;
      exp_valid  = mdl_valid;
   endtask

   task automatic do_reset();
      chk_en = 1'b0;
      rstn_i = 1'b0;
      cyc();
      cyc();
      rstn_i = 1'b1;
      mdl_valid = '0;
      set_exp(1'b1);
      exp_rst = 1'b1;
      chk_en = 1'b1;
      cyc();
      exp_rst = 1'b0;
   endtask

   // fl: 0 none, 1 flush in first WAIT cycle, 2 flush in SEL cycle
   task automatic run_miss(input logic [26:0] vpn, input logic [43:0] ppn,
                           input logic [7:0] perm, input logic [1:0] lvl,
                           input bit flt, input int stall, input int dly,
                           input int fl);
      logic [31:0] vic;
      set_exp(1'b1);
      miss_vld_i = 1'b1;
      miss_vpn_i = vpn;
      t_acc = cyc_n;
      cyc();
      set_exp(1'b0);
      exp_req = 1'b1;
      exp_req_vpn = vpn;
      miss_vld_i = 1'b0;
      for (int i = 0; i < stall; i++) begin
         ptw_req_rdy_i = 1'b0;
         miss_vld_i = 1'b1;
         miss_vpn_i = ~vpn;
         cyc();
      end
      miss_vld_i = 1'b0;
      ptw_req_rdy_i = 1'b1;
      cyc();
      ptw_req_rdy_i = 1'b0;
      set_exp(1'b0);
      for (int i = 0; i < dly; i++) begin
         flush_i = (fl == 1 && i == 0);
         cyc();
         flush_i = 1'b0;
         if (fl == 1 && i == 0) mdl_valid = '0;
         set_exp(1'b0);
      end
      ptw_resp_vld_i = 1'b1;
      ptw_resp_ppn_i = ppn;
      ptw_resp_perm_i = perm;
      ptw_resp_level_i = lvl;
      ptw_resp_fault_i = flt;
      cyc();
      ptw_resp_vld_i = 1'b0;
      ptw_resp_fault_i = 1'b0;
      if (fl == 1) begin
         set_exp(1'b1);
         return;
      end
      if (flt) begin
         set_exp(1'b0);
         exp_fault = 1'b1;
         exp_fault_vpn = vpn;
         cyc();
         set_exp(1'b1);
         return;
      end
      set_exp(1'b0);
      exp_init = 1'b1;
      vic = pick(mdl_valid);
      flush_i = (fl == 2);
      cyc();
      flush_i = 1'b0;
      if (fl == 2) begin
         mdl_valid = '0;
         set_exp(1'b1);
         return;
      end
      set_exp(1'b0);
      exp_refill = 1'b1;
      exp_onehot = vic;
      exp_vpn = vpn;
      exp_ppn = ppn;
      exp_perm = perm;
      exp_lvl = lvl;
      cyc();
      mdl_valid |= vic;
      set_exp(1'b1);
   endtask

   int rc0, fc0;

   initial begin
      set_exp(1'b1);
      do_reset();

      run_miss(27'h123, 44'hABC, 8'hCF, 2'd0, 1'b0, 0, 0, 0);
      #2;
      chk("t1_latency", 64'(refill_cyc - t_acc), 64'd4);
      chk("t1_onehot", {32'd0, last_oh}, 64'h1);
      chk("t1_valid", {32'd0, entry_valid_o}, 64'h1);

      do_reset();
      for (int i = 0; i < 33; i++) begin
         run_miss(27'h1000 + 27'(i), 44'h100 + 44'(i), 8'hCF,
                  2'(i % 3), 1'b0, 0, 0, 0);
         #2;
         if (i == 0) chk("t2_first_oh", {32'd0, last_oh}, 64'h1);
         if (i == 31) begin
            chk("t2_last_oh", {32'd0, last_oh}, 64'h8000_0000);
            chk("t2_full", {32'd0, entry_valid_o}, 64'hFFFF_FFFF);
         end
         if (i == 32) begin
            chk("t2_plru_oh", {32'd0, last_oh}, 64'h80);
            chk("t2_still_full", {32'd0, entry_valid_o}, 64'hFFFF_FFFF);
         end
      end

      run_miss(27'h2AA, 44'h5_5555, 8'h4B, 2'd1, 1'b0, 5, 1, 0);

      rc0 = refill_cnt;
      run_miss(27'h7FF, 44'h0, 8'h0, 2'd0, 1'b1, 0, 2, 0);
      cyc();
      chk("t4_fault_vpn", {37'd0, last_fvpn}, 64'h7FF);
      chk("t4_no_refill", 64'(refill_cnt - rc0), 64'd0);
      chk("t4_valid", {32'd0, entry_valid_o}, 64'hFFFF_FFFF);

      do_reset();
      for (int i = 0; i < 3; i++)
         run_miss(27'h300 + 27'(i), 44'h30 + 44'(i), 8'hCF, 2'd2,
                  1'b0, 0, 0, 0);
      #2;
      chk("t5_three", {32'd0, entry_valid_o}, 64'h7);
      rc0 = refill_cnt;
      fc0 = fault_cnt;
      run_miss(27'h555, 44'h999, 8'hCF, 2'd0, 1'b0, 0, 3, 1);
      cyc();
      cyc();
      chk("t5_flushed", {32'd0, entry_valid_o}, 64'h0);
      chk("t5_no_refill", 64'(refill_cnt - rc0), 64'd0);
      chk("t5_no_fault", 64'(fault_cnt - fc0), 64'd0);

      run_miss(27'h666, 44'h66, 8'hCF, 2'd0, 1'b0, 0, 0, 0);
      rc0 = refill_cnt;
      run_miss(27'h777, 44'h77, 8'hCF, 2'd0, 1'b0, 0, 1, 2);
      cyc();
      chk("t6_no_refill", 64'(refill_cnt - rc0), 64'd0);
      chk("t6_valid", {32'd0, entry_valid_o}, 64'h0);

      run_miss(27'h888, 44'h88, 8'hCF, 2'd1, 1'b0, 0, 0, 0);
      set_exp(1'b1);
      miss_vld_i = 1'b1;
      miss_vpn_i = 27'h3C3;
      cyc();
      miss_vld_i = 1'b0;
      set_exp(1'b0);
      exp_req = 1'b1;
      exp_req_vpn = 27'h3C3;
      ptw_req_rdy_i = 1'b1;
      cyc();
      ptw_req_rdy_i = 1'b0;
      set_exp(1'b0);
      rstn_i = 1'b0;
      cyc();
      rstn_i = 1'b1;
      mdl_valid = '0;
      set_exp(1'b1);
      exp_rst = 1'b1;
      #2;
      chk("t7_valid", {32'd0, entry_valid_o}, 64'h0);
      chk("t7_req_vpn", {37'd0, ptw_req_vpn_o}, 64'h0);
      cyc();
      exp_rst = 1'b0;
      cyc();
      chk_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
